// File: rtl/serial_add_pkg.sv
// ============================================================================
//  Module  : serial_add_pkg
//  Purpose : Shared types and defaults for the bit-serial adder sequencer.
//            Holds the sequencer state encoding and the default operand width.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  // Default operand/result width of the sequencer.
  localparam int DEFAULT_WIDTH = 8;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_fa_cell.sv
// ============================================================================
//  Module  : fa_cell
//  Purpose : Purely combinational 1-bit full adder, the single arithmetic
//            cell reused by the bit-serial sequencer on every bit.
//  Ports   : a, b, c  - input bits and carry-in
//            s        - sum bit
//            co       - carry-out
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
//  Module  : serial_add_ctrl
//  Purpose : Bit-serial adder sequencer. One full-adder cell is stepped over
//            the WIDTH operand bits, LSB first, with a registered carry.
//            Result latency is WIDTH+1 cycles from the start cycle; one add
//            per WIDTH+2 cycles back to back.
//  Ports   : clk, rst_n        - clock, asynchronous active-low reset
//            start, a, b, cin  - request and operands (sampled in IDLE)
//            busy              - high in RUN and DONE (decoded from state)
//            done              - one-cycle registered result-valid pulse
//            sum, cout         - registered result, held until next done
//            sub, ovf          - only with SERIAL_ADD_SUB_EN: subtract
//                                select and signed overflow flag
//  Config  : SERIAL_ADD_SUB_EN enables the add/subtract option.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t             state, next_state;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH-2:0]   acc;       // bits already produced, MSB-aligned
  logic               carry;
  logic [CW-1:0]      bit_cnt;
  logic               fa_s, fa_co;
  logic [WIDTH-1:0]   acc_shifted;
  logic [WIDTH-1:0]   load_b;
  logic               load_carry;

  // The only adder in the design.
  fa_cell u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New bit enters at the MSB; after WIDTH steps this is the full result.
  assign acc_shifted = {fa_s, acc};

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as a + ~b + 1; cin is ignored in that case.
  assign load_b     = sub ? ~b : b;
  assign load_carry = sub ? 1'b1 : cin;
`else
  assign load_b     = b;
  assign load_carry = cin;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (bit_cnt == LAST) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a    <= a;
            op_b    <= load_b;
            carry   <= load_carry;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          acc   <= acc_shifted[WIDTH-1:1];
          carry <= fa_co;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          if (bit_cnt == LAST) begin
            sum  <= acc_shifted;
            cout <= fa_co;
            done <= 1'b1;
`ifdef SERIAL_ADD_SUB_EN
            // carry register holds the carry into the MSB on this cycle
            ovf  <= carry ^ fa_co;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
//  Module  : tb_serial_add_ctrl
//  Purpose : Directed and random self-checking bench for serial_add_ctrl
//            at WIDTH=8. Optional add/subtract checks with SERIAL_ADD_SUB_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int accepted = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Counts every done pulse over the whole run.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-timing directed add: start edge, WIDTH RUN edges, DONE, IDLE.
  task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                        input logic [W-1:0] es, input logic ec, input string tag);
    start = 1'b1; a = ia; b = ib; cin = icin;
    tick();                                   // edge 0
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'b0;
    accepted++;
    check({tag, ".busy0"}, 64'(busy), 64'd1);
    for (int k = 1; k < W; k++) tick();
    check({tag, ".done_early"}, 64'(done), 64'd0);
    tick();                                   // edge W
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".sum"},  64'(sum),  64'(es));
    check({tag, ".cout"}, 64'(cout), 64'(ec));
    tick();                                   // edge W+1
    check({tag, ".busy_fall"}, 64'(busy), 64'd0);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".sum_hold"}, 64'(sum), 64'(es));
  endtask

  initial begin
    int win_dones;
    int k;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   exp9;
    bit           got;

    // Reset state
    #2;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.sum",  64'(sum),  64'd0);
    check("rst.cout", 64'(cout), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "add0f01");
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "addff01");
    do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "addffff1");

    // start held for 20 edges; operands changed after the accepting edge
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    tick();                                   // edge 0
    a = 8'h55; b = 8'hAA;
    win_dones = 0;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (done === 1'b1) win_dones++;
      if (e == 8) begin
        check("hold.done1", 64'(done), 64'd1);
        check("hold.sum1",  64'(sum),  64'h10);
      end
      if (e == 9)  check("hold.idle_gap", 64'(busy), 64'd0);
      if (e == 10) check("hold.reaccept", 64'(busy), 64'd1);
      if (e == 18) begin
        check("hold.done2", 64'(done), 64'd1);
        check("hold.sum2",  64'(sum),  64'hFF);
        check("hold.cout2", 64'(cout), 64'd0);
      end
    end
    start = 1'b0;
    accepted += 2;
    check("hold.ndone", 64'(win_dones), 64'd2);
    tick();
    check("hold.idle_end", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of RUN
    start = 1'b1; a = 8'h33; b = 8'h44; cin = 1'b0;
    tick();                                   // edge 0
    start = 1'b0;
    tick(); tick(); tick();                   // bit_cnt == 3
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.done", 64'(done), 64'd0);
    check("arst.sum",  64'(sum),  64'd0);
    check("arst.cout", 64'(cout), 64'd0);
    win_dones = done_cnt;
    tick(); tick();
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) tick();
    check("arst.no_done", 64'(done_cnt), 64'(win_dones));
    do_add(8'h20, 8'h22, 1'b0, 8'h42, 1'b0, "postrst");

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    do_add(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, "sub0507");
    check("sub0507.ovf", 64'(ovf), 64'd0);
    do_add(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, "sub8001");
    check("sub8001.ovf", 64'(ovf), 64'd1);
    sub = 1'b0;
    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "add7f01");
    check("add7f01.ovf", 64'(ovf), 64'd1);
`endif

    // Random adds with random gaps (gap 0 = back-to-back)
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      start = 1'b1; a = ra; b = rb; cin = rc;
      tick();
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      accepted++;
      got = 1'b0;
      k = 0;
      while (!got && k < 2 * W) begin
        tick();
        k++;
        if (done === 1'b1) got = 1'b1;
      end
      if (!got) begin
        check("rand.timeout", 64'(got), 64'd1);
      end else begin
        check("rand.sum", 64'({cout, sum}), 64'(exp9));
      end
      tick();                                 // back to IDLE
    end

    tick();
    check("done_count", 64'(done_cnt), 64'(accepted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. It time-multiplexes a single 1-bit full-adder cell across the bits of two WIDTH-bit operands, LSB first, with one bit per clock and a registered carry. It presents a start/busy/done handshake to the surrounding logic. It is the area-minimal alternative to a WIDTH-wide ripple adder wherever multi-cycle latency is acceptable.

## Interface
- WIDTH, 8, operand and result width; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an add; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; held stable from done until the next done.
- cout  output  1  carry-out; held with sum.

## Operation
- States:
  - IDLE: on start=1, load op_a←a, op_b←b, carry←cin, bit_cnt←0, and go to RUN.
  - RUN: each cycle, the full-adder cell takes op_a[0], op_b[0] and carry.
    - The cell's sum bit shifts into acc at the MSB (right shift).
    - carry←cell carry.
    - op_a and op_b shift right.
    - bit_cnt increments.
  - On the cycle with bit_cnt==WIDTH-1:
    - sum←final acc, including this cycle's bit.
    - cout←cell carry.
    - Go to DONE.
  - DONE: done=1 for exactly this cycle. Unconditionally return to IDLE.
- start is ignored outside IDLE. A start in RUN or DONE is dropped, not queued.
- Operand inputs a, b and cin may change freely after the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- bit_cnt width: $clog2(WIDTH). It never wraps past WIDTH-1 within an operation.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0. Internal registers are also 0.
- Asserting rst_n mid-operation aborts the add immediately and asynchronously. No done is produced. The next start after reset release behaves normally.

## Timing
- Define edge 0 as the edge sampling start=1 in IDLE. busy=1 from edge 0.
- The WIDTH RUN cycles are bounded by edges 1..WIDTH.
- done=1 and sum/cout are valid in the cycle after edge WIDTH. This is a latency of WIDTH+1 cycles from start to done.
- busy falls after edge WIDTH+1, and IDLE is re-entered then.
- Back-to-back throughput is one add per WIDTH+2 cycles: start may be asserted in the cycle after done.
- busy is combinational from state only. done and sum/cout are registered outputs, so there are no input-to-output combinational paths.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds input port sub (1 bit, sampled with start) and output port ovf (1 bit, held with sum, reset 0).
  - sub=1: operand B is loaded as ~b and carry as 1, so sum = a - b. cin is ignored and cout is the borrow-not.
  - ovf = signed overflow. It is the carry into the MSB XOR the carry out of the MSB, captured on the final RUN cycle. It is valid for both add and sub.
- SERIAL_ADD_SUB_EN undefined: no sub or ovf ports, and behaviour is exactly as above.

## Structure
- The package serial_add_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE), 2-bit encoding;
  - the default WIDTH localparam.
- One sub-module, fa_cell: a purely combinational 1-bit full adder (a, b, c → s, co). It is instantiated exactly once. The sequencer contains no other adder logic.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulse → done exactly 9 cycles after the start edge; sum=8'h10, cout=0; busy falls the following cycle.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- start held high for 20 cycles, with a/b changed to 8'h55/8'hAA after the first edge → first result 8'h10 (from 0F+01) unaffected. The second add is accepted only on the first cycle back in IDLE.
- rst_n pulsed low at RUN bit 3 → busy, done, sum and cout go to 0 asynchronously with no done pulse. A fresh start with 8'h20+8'h22 → sum=8'h42 after 9 cycles.
- Random stimulus, 500 adds with random start gaps → each {cout,sum} matches a+b+cin. done count equals accepted-start count.
- SERIAL_ADD_SUB_EN: sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0, ovf=0. sub=1, a=8'h80, b=8'h01 → sum=8'h7F, ovf=1.
